// File: rtl/dff_pkg.sv
// dff_pkg: shared defaults, stage record type and occupancy-width helper for dff_pipe.
// No ports. Used by dff_pipe via import dff_pkg::*.
package dff_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 3;

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

    function automatic int occ_width(int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one elastic register stage (valid + data) with ready chaining.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      invalidates the stage at the next edge
//   valid_i      upstream stage (or producer) holds a word
//   data_i       upstream word
//   ready_i      downstream stage (or consumer) can take our word
//   ready_o      this stage can take a word: empty, or emptying this cycle
//   valid_o      stage holds a word
//   data_o       stage word
module dff_pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } reg_t;

    reg_t stage_q, stage_d;

    // Data only loads on a real transfer so idle stages keep stale data.
    always_comb begin
        ready_o       = !stage_q.valid | ready_i;
        stage_d.valid = flush_i ? 1'b0 : ready_o ? valid_i : stage_q.valid;
        stage_d.data  = (ready_o & valid_i & !flush_i) ? data_i : stage_q.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stage_q <= '{valid: 1'b0, data: RST_VAL};
        else
            stage_q <= stage_d;
    end

    assign valid_o = stage_q.valid;
    assign data_o  = stage_q.data;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: elastic DEPTH-stage register pipeline with valid/ready and bubble collapsing.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous flush of all stages (blocks input)
//   in_valid/in_ready     producer handshake, in_data word
//   out_valid/out_ready   consumer handshake, out_data word
//   occ                   registered count of occupied stages (only with DFF_PIPE_OCC_EN)
// Optional feature macro: DFF_PIPE_OCC_EN.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    logic             v   [DEPTH];
    logic [WIDTH-1:0] d   [DEPTH];
    logic             rdy [DEPTH];

    // Ready ripples back from the output so an empty stage accepts even when downstream stalls.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v_in, r_in;
        logic [WIDTH-1:0] d_in;
        if (i == 0) begin : g_first
            assign v_in = in_valid;
            assign d_in = in_data;
        end else begin : g_next
            assign v_in = v[i-1];
            assign d_in = d[i-1];
        end
        if (i == DEPTH - 1) begin : g_last
            assign r_in = out_ready;
        end else begin : g_inner
            assign r_in = rdy[i+1];
        end
        dff_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .valid_i (v_in),
            .data_i  (d_in),
            .ready_i (r_in),
            .ready_o (rdy[i]),
            .valid_o (v[i]),
            .data_o  (d[i])
        );
    end

    assign in_ready  = rdy[0] & !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
    localparam int OW = occ_width(DEPTH);
    logic [OW-1:0] occ_q, occ_d;
    // Tracks the popcount of the valids incrementally from the two handshakes.
    always_comb
        occ_d = flush ? '0 : occ_q + OW'(in_valid & in_ready) - OW'(out_valid & out_ready);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            occ_q <= '0;
        else
            occ_q <= occ_d;
    end
    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: scoreboard bench for dff_pipe (WIDTH=8, DEPTH=3, RST_VAL=0).
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
`ifdef DFF_PIPE_OCC_EN
    logic [1:0] occ;
`endif

    int         tests = 0;
    int         fails = 0;
    int         stalls = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DFF_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    // Monitor: every output transfer must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: got %h expected no word", out_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL sb_data: got %h expected %h", out_data, e);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer x until accepted (bounded), record it as expected, then drop in_valid.
    task automatic send(logic [7:0] x);
        int n = 0;
        in_valid = 1'b1;
        in_data  = x;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            stalls++;
            n++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 for %h", x);
        end else
            sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(string name);
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_timeout"}, 32'(n < 50), 1);
        chk({name, "_left"}, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        // 1. reset state and latency
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 1);
`ifdef DFF_PIPE_OCC_EN
        chk("rst_occ", occ, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        send(8'hA5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("lat_valid_%0d", k), out_valid, 32'(k == 3));
        end
        drain("t1");
        // 2. streaming
        @(posedge clk);
        #1;
        stalls = 0;
        for (int i = 1; i <= 16; i++)
            send(8'(i));
        chk("stream_stalls", stalls, 0);
        drain("t2");
        // 3. backpressure / full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        in_valid = 1'b1;
        in_data  = 8'h04;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
`ifdef DFF_PIPE_OCC_EN
        chk("full_occ", occ, 3);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_adv_in_ready", in_ready, 1);
        if (in_ready) sb.push_back(8'h04);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drain("t3");
        // 4. bubble collapse
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h11);
        @(posedge clk);
        #1;
        send(8'h22);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bubble_out_valid", out_valid, 1);
        chk("bubble_in_ready", in_ready, 1);
`ifdef DFF_PIPE_OCC_EN
        chk("bubble_occ", occ, 2);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bubble_adjacent", out_valid, 1);
        drain("t4");
        // 5. flush
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        sb.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
`ifdef DFF_PIPE_OCC_EN
        chk("flush_occ", occ, 0);
`endif
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_stays_empty", out_valid, 0);
        // 6. asynchronous reset mid-stream
        out_ready = 1'b0;
        send(8'h41);
        send(8'h42);
        send(8'h43);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 8'h00);
        chk("arst_in_ready", in_ready, 1);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("arst_no_old_word", out_valid, 0);
        send(8'h5A);
        drain("t6");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
